// File: rtl/muldiv_unit_if.sv
// Handshake, operand and HI/LO bus between the controller (master) and muldiv_unit (slave).
// Signal names follow the unit's port list; clk and rst stay outside the interface.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Fixed latency WIDTH+2 from start to done; operands are handled as magnitudes with signs fixed up at the end.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic                 r_sign_a;
    logic                 r_sign_res;
    logic                 r_bzero;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dbz;

    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic en);
        return en ? ({WIDTH{1'b0}} - x) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? ({(2*WIDTH){1'b0}} - x) : x;
    endfunction

    // Operand capture: magnitudes plus the two sign bits needed for the final fix-up.
    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_signed = ~bus.op[0];
    assign w_abs_a  = cneg(bus.a, w_signed & bus.a[WIDTH-1]);
    assign w_abs_b  = cneg(bus.b, w_signed & bus.b[WIDTH-1]);

    // Multiply step: r_acc = {partial high, remaining multiplier bits}, add then shift right.
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_addend   = r_acc[0] ? r_mag_a : {WIDTH{1'b0}};
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: r_acc = {remainder, dividend bits shifting into quotient}, restoring subtract.
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem_sh - {1'b0, r_mag_b};
    assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    // Fix-up: most-negative / -1 needs no special case, the magnitude quotient already wraps correctly.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod = cneg2(r_acc, r_sign_res);

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_bzero) begin
                w_fix_hi = cneg(r_mag_a, r_sign_a);
                w_fix_lo = {WIDTH{1'b1}};
            end else begin
                w_fix_hi = cneg(r_acc[2*WIDTH-1:WIDTH], r_sign_a);
                w_fix_lo = cneg(r_acc[WIDTH-1:0], r_sign_res);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_CALC;
            S_CALC:  if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_sign_a   <= 1'b0;
            r_sign_res <= 1'b0;
            r_bzero    <= 1'b0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    if (bus.start) begin
                        r_cnt      <= '0;
                        r_is_div   <= bus.op[1];
                        r_mag_a    <= w_abs_a;
                        r_mag_b    <= w_abs_b;
                        r_sign_a   <= w_signed & bus.a[WIDTH-1];
                        r_sign_res <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_bzero    <= (bus.b == {WIDTH{1'b0}});
                        r_acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                    r_dbz  <= r_is_div & r_bzero;
                    r_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    // Result of one operation straight from the arithmetic definition: {div_by_zero, hi, lo}.
    function automatic logic [64:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] h, l;
        logic        z;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z = 1'b0;
        h = '0;
        l = '0;
        case (op)
            2'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            2'd1: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    h = a; l = '1; z = 1'b1;
                end else if (op == 2'd2) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        l = a; h = '0;
                    end else begin
                        q = sa / sb; r = sa % sb;
                        l = q[31:0]; h = r[31:0];
                    end
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
        return {z, h, l};
    endfunction

    // Cycle model: result lands W+2 cycles after the start edge; writes and starts only when idle.
    int          m_cnt;
    logic [31:0] m_hi, m_lo;
    logic        m_done, m_dbz;
    logic [64:0] m_pend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dbz <= 1'b0; m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_cnt == 0) begin
                if (bus.hi_we) m_hi <= bus.wdata;
                if (bus.lo_we) m_lo <= bus.wdata;
                if (bus.start) begin
                    m_pend <= ref_res(bus.op, bus.a, bus.b);
                    m_cnt  <= 1;
                end
            end else if (m_cnt == W + 1) begin
                m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0];
                m_done <= 1'b1; m_dbz <= m_pend[64]; m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 32'(bus.busy), 32'(m_cnt != 0));
            chk("cyc_done", 32'(bus.done), 32'(m_done));
            chk("cyc_dbz",  32'(bus.div_by_zero), 32'(m_dbz));
            chk("cyc_hi",   bus.hi, m_hi);
            chk("cyc_lo",   bus.lo, m_lo);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    endtask

    // Called right after the negedge where start was raised; returns at the negedge of the done cycle.
    task automatic wait_done(input bit abuse, output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            if (lat == 1) begin
                bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
            end
            if (abuse) begin
                if (lat == 5)  begin bus.start = 1'b1; bus.a = 32'h55; bus.b = 32'h3; bus.op = 2'd1; end
                if (lat == 6)  bus.start = 1'b0;
                if (lat == 10) begin bus.hi_we = 1'b1; bus.wdata = 32'h1234; end
                if (lat == 11) bus.hi_we = 1'b0;
            end
            if (bus.done === 1'b1) break;
        end
        if (bus.done !== 1'b1) begin
            checks++; failures++;
            $display("FAIL timeout waiting for done lat=%0d required=%0d", lat, W + 2);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat, bn;
        logic [64:0] r;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'h0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Pin the reference model with hand-computed values.
        r = ref_res(2'd0, 32'hFFFF_FFFF, 32'd2);
        chk("model_mult_hi", r[63:32], 32'hFFFF_FFFF);
        chk("model_mult_lo", r[31:0], 32'hFFFF_FFFE);
        r = ref_res(2'd1, 32'hFFFF_FFFF, 32'd2);
        chk("model_multu_hi", r[63:32], 32'h0000_0001);
        r = ref_res(2'd2, 32'hFFFF_FFF9, 32'd2);
        chk("model_div_lo", r[31:0], 32'hFFFF_FFFD);
        chk("model_div_hi", r[63:32], 32'hFFFF_FFFF);
        r = ref_res(2'd3, 32'd7, 32'd0);
        chk("model_dbz", 32'(r[64]), 32'h1);

        @(negedge clk); issue(2'd0, 32'hFFFF_FFFF, 32'd2);
        wait_done(1'b0, lat, bn);
        chk("mult_lat", 32'(lat), 32'd34);
        chk("mult_busy_cycles", 32'(bn), 32'd33);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFE);

        @(negedge clk); issue(2'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done(1'b0, lat, bn);
        chk("multu_hi", bus.hi, 32'h0000_0001);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

        @(negedge clk); issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, lat, bn);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        chk("div_dbz", 32'(bus.div_by_zero), 32'h0);

        @(negedge clk); issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, lat, bn);
        chk("divmin_lo", bus.lo, 32'h8000_0000);
        chk("divmin_hi", bus.hi, 32'h0);

        @(negedge clk); issue(2'd3, 32'd7, 32'd0);
        wait_done(1'b0, lat, bn);
        chk("dbz_lat", 32'(lat), 32'd34);
        chk("dbz_hi", bus.hi, 32'h7);
        chk("dbz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("dbz_flag", 32'(bus.div_by_zero), 32'h1);
        @(negedge clk);
        chk("dbz_one_cycle", 32'(bus.div_by_zero), 32'h0);

        issue(2'd3, 32'd1000, 32'd3);
        wait_done(1'b1, lat, bn);
        chk("abuse_lat", 32'(lat), 32'd34);
        chk("abuse_lo", bus.lo, 32'd333);
        chk("abuse_hi", bus.hi, 32'd1);
        issue(2'd2, 32'hFFFF_FF9C, 32'd7);
        wait_done(1'b0, lat, bn);
        chk("chain_lat", 32'(lat), 32'd34);
        chk("chain_busy_cycles", 32'(bn), 32'd33);
        chk("chain_lo", bus.lo, 32'hFFFF_FFF2);
        chk("chain_hi", bus.hi, 32'hFFFF_FFFE);

        @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("mt_hi", bus.hi, 32'hA5A5_A5A5);
        chk("mt_lo", bus.lo, 32'hA5A5_A5A5);
        chk("mt_done", 32'(bus.done), 32'h0);

        issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_hi", bus.hi, 32'h0);
        chk("arst_lo", bus.lo, 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_done", 32'(bus.done), 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); issue(2'd3, 32'd100, 32'd7);
        wait_done(1'b0, lat, bn);
        chk("post_rst_lo", bus.lo, 32'd14);
        chk("post_rst_hi", bus.hi, 32'd2);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 2'($urandom);
            bus.a     = pick();
            bus.b     = pick();
            bus.hi_we = ($urandom_range(0, 7) == 0);
            bus.lo_we = ($urandom_range(0, 7) == 0);
            bus.wdata = $urandom;
        end
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
